next_line_prefetch_buffer: RTL and testbench

- Read-direction companion to the L2-side eviction path; sits between the L2 cache and physical memory.
- Passes L2 line reads and writes through to pmem.
- After every L2 read, fetches the next sequential 32-byte line into a single-entry buffer. A later L2 read to that line is answered from the buffer in one cycle, with no pmem access.
- Uses the same L2/pmem read/write/resp handshake as the rest of the memory hierarchy.

---
 rtl/next_line_prefetch_buffer_if.sv | 16 +
 rtl/next_line_prefetch_buffer.sv | 134 +++++++++++++
 tb/tb_next_line_prefetch_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/next_line_prefetch_buffer_if.sv
// Line-granular read/write/resp handshake shared by the L2 side and the pmem side.
// The requester uses master; the responder uses slave.
interface next_line_prefetch_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  read;
  logic                  write;
  logic                  resp;

  modport master (output addr, wdata, read, write, input rdata, resp);
  modport slave  (input addr, wdata, read, write, output rdata, resp);
endinterface

// File: rtl/next_line_prefetch_buffer.sv
// Pass-through between L2 and pmem. After every L2 read it prefetches the next
// sequential line into a one-entry buffer, so a later read of that line completes in one cycle.
module next_line_prefetch_buffer #(
  parameter int LINE_OFFSET = 5,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  next_line_prefetch_buffer_if.slave   l2,
  next_line_prefetch_buffer_if.master  pmem
);
  localparam int TAG_W     = ADDR_WIDTH - LINE_OFFSET;
  localparam int LINE_BITS = 8 << LINE_OFFSET;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HIT_RESP   = 3'd1,
    FETCH      = 3'd2,
    PREFETCH   = 3'd3,
    WRITE_THRU = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [TAG_W-1:0]       buf_tag_q, buf_tag_d;
  logic [LINE_BITS-1:0]   buf_data_q, buf_data_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]       pf_tag_q, pf_tag_d;

  logic [TAG_W-1:0]       l2_tag;
  logic                   hit;
  logic [LINE_BITS-1:0]   l2_rdata_o;
  logic                   l2_resp_o;
  logic [ADDR_WIDTH-1:0]  pmem_addr_o;
  logic [LINE_BITS-1:0]   pmem_wdata_o;
  logic                   pmem_read_o;
  logic                   pmem_write_o;

  assign l2_tag = l2.addr[ADDR_WIDTH-1:LINE_OFFSET];
  assign hit    = buf_valid_q && (l2_tag == buf_tag_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      pf_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      pf_tag_q    <= pf_tag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    buf_valid_d  = buf_valid_q;
    pf_tag_d     = pf_tag_q;
    l2_rdata_o   = '0;
    l2_resp_o    = 1'b0;
    pmem_addr_o  = '0;
    pmem_wdata_o = l2.wdata;
    pmem_read_o  = 1'b0;
    pmem_write_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (l2.read) begin
          state_d = hit ? HIT_RESP : FETCH;
        end else if (l2.write) begin
          state_d = WRITE_THRU;
          // A write to the buffered line makes the copy stale.
          if (hit) buf_valid_d = 1'b0;
        end
      end
      HIT_RESP: begin
        l2_rdata_o = buf_data_q;
        l2_resp_o  = 1'b1;
        pf_tag_d   = buf_tag_q + TAG_W'(1);
        state_d    = PREFETCH;
      end
      FETCH: begin
        pmem_read_o = 1'b1;
        pmem_addr_o = {l2_tag, {LINE_OFFSET{1'b0}}};
        l2_rdata_o  = pmem.rdata;
        l2_resp_o   = pmem.resp;
        if (pmem.resp) begin
          pf_tag_d    = l2_tag + TAG_W'(1);
          buf_valid_d = 1'b0;
          state_d     = PREFETCH;
        end
      end
      PREFETCH: begin
        // Not abortable; new L2 requests wait here and are decoded in IDLE.
        pmem_read_o = 1'b1;
        pmem_addr_o = {pf_tag_q, {LINE_OFFSET{1'b0}}};
        if (pmem.resp) begin
          buf_data_d  = pmem.rdata;
          buf_tag_d   = pf_tag_q;
          buf_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE_THRU: begin
        pmem_write_o = 1'b1;
        pmem_addr_o  = l2.addr;
        l2_resp_o    = pmem.resp;
        if (pmem.resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs go quiet the moment reset is asserted, not at the next edge.
    if (rst) begin
      l2_rdata_o   = '0;
      l2_resp_o    = 1'b0;
      pmem_addr_o  = '0;
      pmem_wdata_o = '0;
      pmem_read_o  = 1'b0;
      pmem_write_o = 1'b0;
    end
  end

  assign l2.rdata   = l2_rdata_o;
  assign l2.resp    = l2_resp_o;
  assign pmem.addr  = pmem_addr_o;
  assign pmem.wdata = pmem_wdata_o;
  assign pmem.read  = pmem_read_o;
  assign pmem.write = pmem_write_o;
endmodule

// File: tb/tb_next_line_prefetch_buffer.sv
// Directed bench for next_line_prefetch_buffer. pmem answers each request
// three cycles after it appears, with data derived from the line address.
module tb_next_line_prefetch_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  next_line_prefetch_buffer_if l2_bus ();
  next_line_prefetch_buffer_if pmem_bus ();

  next_line_prefetch_buffer dut (
    .clk  (clk),
    .rst  (rst),
    .l2   (l2_bus),
    .pmem (pmem_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_data(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  int           lat_cnt = 0;
  int           rd_cnt  = 0;
  int           wr_cnt  = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wr_addr = '0;
  logic [255:0] last_wr_data = '0;
  logic         both_seen = 1'b0;

  // pmem model: answers on the third cycle a request is held, drives away from the edge.
  initial begin
    pmem_bus.resp  = 1'b0;
    pmem_bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pmem_bus.resp = 1'b0;
        lat_cnt = 0;
      end else if (pmem_bus.resp) begin
        pmem_bus.resp = 1'b0;
        lat_cnt = 0;
      end else if (pmem_bus.read || pmem_bus.write) begin
        if (pmem_bus.read && pmem_bus.write) both_seen = 1'b1;
        lat_cnt++;
        if (lat_cnt == 3) begin
          pmem_bus.resp = 1'b1;
          if (pmem_bus.read) begin
            pmem_bus.rdata = line_data(pmem_bus.addr);
            rd_cnt++;
            last_rd_addr = pmem_bus.addr;
          end else begin
            wr_cnt++;
            last_wr_addr = pmem_bus.addr;
            last_wr_data = pmem_bus.wdata;
          end
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Called and returns at a negedge; cyc counts negedges until L2 resp is seen.
  task automatic do_read(input logic [31:0] a, output logic [255:0] d, output int cyc);
    l2_bus.addr = a;
    l2_bus.read = 1'b1;
    cyc = 0;
    d   = '0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!l2_bus.resp && cyc < 100);
    check_eq("read_resp", l2_bus.resp, 1);
    d = l2_bus.rdata;
    l2_bus.read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] w, output int cyc);
    l2_bus.addr  = a;
    l2_bus.wdata = w;
    l2_bus.write = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!l2_bus.resp && cyc < 100);
    check_eq("write_resp", l2_bus.resp, 1);
    l2_bus.write = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (!pmem_bus.read && !pmem_bus.write) q++;
      else q = 0;
    end
    check_eq("quiet", (q >= 3), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    int           cyc;
    int           n0;
    logic [255:0] w;

    rst          = 1'b1;
    l2_bus.read  = 1'b0;
    l2_bus.write = 1'b0;
    l2_bus.addr  = 32'h0000_1000;
    l2_bus.wdata = {8{32'hDEAD_BEEF}};
    repeat (2) @(negedge clk);
    check_eq("rst_l2_resp", l2_bus.resp, 0);
    check_eq("rst_pmem_read", pmem_bus.read, 0);
    check_eq("rst_pmem_write", pmem_bus.write, 0);
    check_eq("rst_l2_rdata", l2_bus.rdata, 0);
    check_eq("rst_pmem_addr", pmem_bus.addr, 0);
    check_eq("rst_pmem_wdata", pmem_bus.wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // cold read, then prefetch of the next line
    do_read(32'h0000_1000, d, cyc);
    check_eq("cold_data", d, line_data(32'h0000_1000));
    check_eq("cold_lat", cyc, 3);
    check_eq("cold_addr", last_rd_addr, 32'h0000_1000);
    wait_quiet();
    check_eq("pf1_addr", last_rd_addr, 32'h0000_1020);
    check_eq("pf1_cnt", rd_cnt, 2);

    // hit inside the buffered line
    n0 = rd_cnt;
    do_read(32'h0000_1034, d, cyc);
    check_eq("hit_data", d, line_data(32'h0000_1020));
    check_eq("hit_lat", cyc, 1);
    check_eq("hit_no_pmem", rd_cnt, n0);
    wait_quiet();
    check_eq("pf2_addr", last_rd_addr, 32'h0000_1040);
    check_eq("pf2_cnt", rd_cnt, n0 + 1);

    // write to the buffered line invalidates it
    do_read(32'h0000_2000, d, cyc);
    wait_quiet();
    check_eq("pf3_addr", last_rd_addr, 32'h0000_2020);
    n0 = rd_cnt;
    w  = {8{32'h1234_5678}};
    do_write(32'h0000_2020, w, cyc);
    check_eq("wr_lat", cyc, 3);
    check_eq("wr_addr", last_wr_addr, 32'h0000_2020);
    check_eq("wr_data", last_wr_data, w);
    wait_quiet();
    check_eq("wr_no_pf", rd_cnt, n0);
    do_read(32'h0000_2020, d, cyc);
    check_eq("inval_lat", cyc, 3);
    check_eq("inval_cnt", rd_cnt, n0 + 1);
    check_eq("inval_addr", last_rd_addr, 32'h0000_2020);
    check_eq("inval_data", d, line_data(32'h0000_2020));
    wait_quiet();

    // tag wrap at top of address space
    do_read(32'hFFFF_FFE0, d, cyc);
    check_eq("top_data", d, line_data(32'hFFFF_FFE0));
    wait_quiet();
    check_eq("wrap_pf_addr", last_rd_addr, 32'h0000_0000);
    do_read(32'h0000_0000, d, cyc);
    check_eq("wrap_hit_lat", cyc, 1);
    check_eq("wrap_hit_data", d, line_data(32'h0000_0000));
    wait_quiet();

    // request arriving during an in-flight prefetch stalls, then misses
    do_read(32'h0000_1000, d, cyc);
    wait_quiet();
    do_read(32'h0000_1020, d, cyc);
    check_eq("stall_pre_hit", cyc, 1);
    n0 = rd_cnt;
    do_read(32'h0000_3000, d, cyc);
    check_eq("stall_lat", cyc, 7);
    check_eq("stall_data", d, line_data(32'h0000_3000));
    check_eq("stall_cnt", rd_cnt, n0 + 2);
    check_eq("stall_addr", last_rd_addr, 32'h0000_3000);
    wait_quiet();
    check_eq("stall_pf_addr", last_rd_addr, 32'h0000_3020);

    // asynchronous reset in FETCH
    n0 = rd_cnt;
    l2_bus.addr = 32'h0000_5000;
    l2_bus.read = 1'b1;
    @(negedge clk);
    check_eq("fetch_read", pmem_bus.read, 1);
    check_eq("fetch_addr", pmem_bus.addr, 32'h0000_5000);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_pmem_read", pmem_bus.read, 0);
    check_eq("arst_l2_resp", l2_bus.resp, 0);
    check_eq("arst_pmem_addr", pmem_bus.addr, 0);
    l2_bus.read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(32'h0000_3020, d, cyc);
    check_eq("post_rst_lat", cyc, 3);
    check_eq("post_rst_cnt", rd_cnt, n0 + 1);
    check_eq("post_rst_data", d, line_data(32'h0000_3020));
    wait_quiet();

    check_eq("rd_wr_overlap", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
